// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data memory between the pipeline MEM
// stage (CPU port) and the debug/DMA port. The CPU wins by default; a
// starvation counter forces a debug grant after MAX_WAIT lost cycles.
// Read data is routed back to its owner RD_LAT cycles after the grant.
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int RD_LAT     = 1,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_funct3,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [15:0]           stall_count
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic [2:0] F3_WORD    = 3'b010;

  logic              w_dbg_win;
  logic              w_cpu_gnt;
  logic              w_cpu_stall;
  logic              w_rd_issue;
  logic              w_out_vld;
  logic [3:0]        r_starve_cnt;
  logic [RD_LAT-1:0] r_rd_vld_p;
  logic [RD_LAT-1:0] r_rd_own_p;   // 1 = debug owns the read, 0 = CPU
  logic [15:0]       r_stall_count;

  // Internal grant decisions are left ungated so the counters see the true
  // contention; every output below is forced to 0 while reset is high.
  assign w_dbg_win   = dbg_req & (~cpu_req | (r_starve_cnt == MAX_WAIT_C));
  assign w_cpu_gnt   = cpu_req & ~w_dbg_win;
  assign w_cpu_stall = cpu_req & ~w_cpu_gnt;
  assign w_rd_issue  = (w_cpu_gnt & ~cpu_we) | (w_dbg_win & ~dbg_we);

  assign cpu_stall   = w_cpu_stall & ~reset;
  assign dbg_gnt     = w_dbg_win & ~reset;
  assign stall_count = reset ? 16'h0000 : r_stall_count;

  // Route the granted requester onto the memory command bus.
  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = 3'b000;
    if (!reset) begin
      if (w_cpu_gnt) begin
        mem_rd     = ~cpu_we;
        mem_wr     = cpu_we;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        mem_funct3 = cpu_funct3;
      end else if (w_dbg_win) begin
        mem_rd     = ~dbg_we;
        mem_wr     = dbg_we;
        mem_addr   = dbg_addr;
        mem_wdata  = dbg_wdata;
        mem_funct3 = F3_WORD;
      end
    end
  end

  // Count consecutive cycles a pending debug request loses, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= 4'd0;
    end else if (!dbg_req || w_dbg_win) begin
      r_starve_cnt <= 4'd0;
    end else if (r_starve_cnt != MAX_WAIT_C) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Stage boundary: read-return tracking, one slot per cycle of memory latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_vld_p <= '0;
    end else begin
      r_rd_vld_p[0] <= w_rd_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rd_vld_p[i] <= r_rd_vld_p[i-1];
      end
    end
  end

  // Owner tag travels alongside the valid bit; it needs no reset.
  always_ff @(posedge clk) begin
    r_rd_own_p[0] <= w_dbg_win;
    for (int i = 1; i < RD_LAT; i++) begin
      r_rd_own_p[i] <= r_rd_own_p[i-1];
    end
  end

  assign w_out_vld  = r_rd_vld_p[RD_LAT-1] & ~reset;
  assign cpu_rvalid = w_out_vld & ~r_rd_own_p[RD_LAT-1];
  assign dbg_rvalid = w_out_vld & r_rd_own_p[RD_LAT-1];
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

  // Saturating count of cycles in which the pipeline was frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= 16'h0000;
    end else if (w_cpu_stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter. Three instances share the
// request inputs: A (RD_LAT=1, MAX_WAIT=4), B (RD_LAT=3, MAX_WAIT=4) and
// C (RD_LAT=2, MAX_WAIT=1). Memory array is written by A only.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [8:0]  cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata;
  logic [2:0]  cpu_funct3;

  logic        a_cpu_stall, a_cpu_rvalid, a_dbg_gnt, a_dbg_rvalid, a_mem_rd, a_mem_wr;
  logic [31:0] a_cpu_rdata, a_dbg_rdata, a_mem_wdata, a_mem_rdata;
  logic [8:0]  a_mem_addr;
  logic [2:0]  a_mem_funct3;
  logic [15:0] a_stall_count;

  logic        b_cpu_stall, b_cpu_rvalid, b_dbg_gnt, b_dbg_rvalid, b_mem_rd, b_mem_wr;
  logic [31:0] b_cpu_rdata, b_dbg_rdata, b_mem_wdata, b_mem_rdata;
  logic [8:0]  b_mem_addr;
  logic [2:0]  b_mem_funct3;
  logic [15:0] b_stall_count;

  logic        c_cpu_stall, c_cpu_rvalid, c_dbg_gnt, c_dbg_rvalid, c_mem_rd, c_mem_wr;
  logic [31:0] c_cpu_rdata, c_dbg_rdata, c_mem_wdata, c_mem_rdata;
  logic [8:0]  c_mem_addr;
  logic [2:0]  c_mem_funct3;
  logic [15:0] c_stall_count;

  dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .RD_LAT(1), .MAX_WAIT(4)) u_a (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_funct3(cpu_funct3), .cpu_stall(a_cpu_stall), .cpu_rvalid(a_cpu_rvalid),
    .cpu_rdata(a_cpu_rdata), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(a_dbg_gnt), .dbg_rvalid(a_dbg_rvalid),
    .dbg_rdata(a_dbg_rdata), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_funct3(a_mem_funct3), .mem_rdata(a_mem_rdata),
    .stall_count(a_stall_count));

  dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .RD_LAT(3), .MAX_WAIT(4)) u_b (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_funct3(cpu_funct3), .cpu_stall(b_cpu_stall), .cpu_rvalid(b_cpu_rvalid),
    .cpu_rdata(b_cpu_rdata), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(b_dbg_gnt), .dbg_rvalid(b_dbg_rvalid),
    .dbg_rdata(b_dbg_rdata), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_funct3(b_mem_funct3), .mem_rdata(b_mem_rdata),
    .stall_count(b_stall_count));

  dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .RD_LAT(2), .MAX_WAIT(1)) u_c (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_funct3(cpu_funct3), .cpu_stall(c_cpu_stall), .cpu_rvalid(c_cpu_rvalid),
    .cpu_rdata(c_cpu_rdata), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(c_dbg_gnt), .dbg_rvalid(c_dbg_rvalid),
    .dbg_rdata(c_dbg_rdata), .mem_rd(c_mem_rd), .mem_wr(c_mem_wr), .mem_addr(c_mem_addr),
    .mem_wdata(c_mem_wdata), .mem_funct3(c_mem_funct3), .mem_rdata(c_mem_rdata),
    .stall_count(c_stall_count));

  // Word memory model with per-instance read latency.
  logic [31:0] mem [0:127];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [0:2];
  logic [31:0] pipe_c [0:1];

  always @(posedge clk) begin
    if (a_mem_wr) mem[a_mem_addr[8:2]] <= a_mem_wdata;
    pipe_a    <= mem[a_mem_addr[8:2]];
    pipe_b[0] <= mem[b_mem_addr[8:2]];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    pipe_c[0] <= mem[c_mem_addr[8:2]];
    pipe_c[1] <= pipe_c[0];
  end

  assign a_mem_rdata = pipe_a;
  assign b_mem_rdata = pipe_b[2];
  assign c_mem_rdata = pipe_c[1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 1 time unit after the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #5;
  endtask

  task automatic idle();
    cpu_req = 1'b0;
    dbg_req = 1'b0;
  endtask

  task automatic cpu_drv(input logic we, input logic [8:0] addr, input logic [31:0] wd);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_funct3 = 3'b010;
  endtask

  task automatic dbg_drv(input logic we, input logic [8:0] addr, input logic [31:0] wd);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
  endtask

  logic [8:0]  pre_addr [4];
  logic [31:0] pre_data [4];
  logic [31:0] exp_v;

  initial begin
    pre_addr = '{9'h010, 9'h004, 9'h008, 9'h00C};
    pre_data = '{32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h33333333};
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    // Reset with both requests asserted: every output must be 0.
    tick();
    cpu_drv(1'b0, 9'h010, 32'h0);
    dbg_drv(1'b1, 9'h020, 32'hA5A5A5A5);
    smp();
    check("rst_cpu_stall", 32'(a_cpu_stall), 32'd0);
    check("rst_dbg_gnt",   32'(a_dbg_gnt),   32'd0);
    check("rst_mem_rd",    32'(a_mem_rd),    32'd0);
    check("rst_mem_wr",    32'(a_mem_wr),    32'd0);
    check("rst_mem_addr",  32'(a_mem_addr),  32'd0);
    check("rst_mem_wdata", a_mem_wdata,      32'd0);
    check("rst_stall_cnt", 32'(a_stall_count), 32'd0);
    check("rst_c_dbg_gnt", 32'(c_dbg_gnt),   32'd0);
    tick();
    smp();
    tick();
    reset = 1'b0;
    idle();
    smp();
    check("post_rst_stall_cnt", 32'(a_stall_count), 32'd0);
    check("post_rst_mem_rd",    32'(a_mem_rd),      32'd0);
    check("post_rst_mem_wr",    32'(a_mem_wr),      32'd0);
    check("post_rst_rvalid",    32'(a_cpu_rvalid),  32'd0);

    // Load memory words through uncontended CPU writes.
    for (int i = 0; i < 4; i++) begin
      tick();
      cpu_drv(1'b1, pre_addr[i], pre_data[i]);
      smp();
      check("pre_mem_wr", 32'(a_mem_wr),    32'd1);
      check("pre_stall",  32'(a_cpu_stall), 32'd0);
    end

    // CPU-only read, RD_LAT=1.
    tick();
    cpu_drv(1'b0, 9'h010, 32'h0);
    smp();
    check("cpu_rd_mem_rd",   32'(a_mem_rd),     32'd1);
    check("cpu_rd_stall",    32'(a_cpu_stall),  32'd0);
    check("cpu_rd_addr",     32'(a_mem_addr),   32'h010);
    check("cpu_rd_early_rv", 32'(a_cpu_rvalid), 32'd0);
    tick();
    idle();
    smp();
    check("cpu_rvalid",      32'(a_cpu_rvalid), 32'd1);
    check("cpu_rdata",       a_cpu_rdata,       32'hDEADBEEF);
    check("cpu_rd_dbg_rv",   32'(a_dbg_rvalid), 32'd0);
    tick();
    smp();
    check("cpu_rvalid_off",  32'(a_cpu_rvalid), 32'd0);
    check("cpu_rdata_zero",  a_cpu_rdata,       32'd0);

    // Debug-only write then read, forced to word size.
    tick();
    dbg_drv(1'b1, 9'h020, 32'h12345678);
    cpu_funct3 = 3'b100;
    smp();
    check("dbg_wr_gnt",    32'(a_dbg_gnt),    32'd1);
    check("dbg_wr_mem_wr", 32'(a_mem_wr),     32'd1);
    check("dbg_wr_mem_rd", 32'(a_mem_rd),     32'd0);
    check("dbg_wr_funct3", 32'(a_mem_funct3), 32'd2);
    check("dbg_wr_wdata",  a_mem_wdata,       32'h12345678);
    check("dbg_wr_addr",   32'(a_mem_addr),   32'h020);
    tick();
    idle();
    smp();
    check("dbg_gnt_pulse", 32'(a_dbg_gnt),    32'd0);
    tick();
    dbg_drv(1'b0, 9'h020, 32'h0);
    smp();
    check("dbg_rd_gnt",    32'(a_dbg_gnt),    32'd1);
    check("dbg_rd_mem_rd", 32'(a_mem_rd),     32'd1);
    check("dbg_rd_funct3", 32'(a_mem_funct3), 32'd2);
    tick();
    idle();
    smp();
    check("dbg_rvalid",    32'(a_dbg_rvalid), 32'd1);
    check("dbg_rdata",     a_dbg_rdata,       32'h12345678);
    check("dbg_rd_cpu_rv", 32'(a_cpu_rvalid), 32'd0);

    // Continuous contention: A debug wins every 5th cycle, C every 2nd.
    for (int k = 0; k < 10; k++) begin
      tick();
      cpu_drv(1'b0, 9'h010, 32'h0);
      dbg_drv(1'b0, 9'h020, 32'h0);
      smp();
      check("cont_a_dbg_gnt", 32'(a_dbg_gnt),   (k % 5 == 4) ? 32'd1 : 32'd0);
      check("cont_a_stall",   32'(a_cpu_stall), (k % 5 == 4) ? 32'd1 : 32'd0);
      check("cont_c_dbg_gnt", 32'(c_dbg_gnt),   (k % 2 == 1) ? 32'd1 : 32'd0);
      check("cont_a_stall_cnt", 32'(a_stall_count), (k >= 5) ? 32'd1 : 32'd0);
    end
    tick();
    idle();
    smp();
    check("cont_a_stall_cnt_end", 32'(a_stall_count), 32'd2);
    check("cont_b_stall_cnt_end", 32'(b_stall_count), 32'd2);
    check("cont_c_stall_cnt_end", 32'(c_stall_count), 32'd5);
    for (int k = 0; k < 4; k++) tick();

    // Interleaved reads on B (RD_LAT=3): CPU 004, DBG 008, CPU 00C.
    for (int k = 0; k < 7; k++) begin
      tick();
      idle();
      if (k == 0) cpu_drv(1'b0, 9'h004, 32'h0);
      if (k == 1) dbg_drv(1'b0, 9'h008, 32'h0);
      if (k == 2) cpu_drv(1'b0, 9'h00C, 32'h0);
      smp();
      if (k == 1) check("il_b_dbg_gnt", 32'(b_dbg_gnt), 32'd1);
      check("il_b_cpu_rvalid", 32'(b_cpu_rvalid), (k == 3 || k == 5) ? 32'd1 : 32'd0);
      check("il_b_dbg_rvalid", 32'(b_dbg_rvalid), (k == 4) ? 32'd1 : 32'd0);
      exp_v = (k == 3) ? 32'h11111111 : (k == 5) ? 32'h33333333 : 32'd0;
      check("il_b_cpu_rdata", b_cpu_rdata, exp_v);
      exp_v = (k == 4) ? 32'h22222222 : 32'd0;
      check("il_b_dbg_rdata", b_dbg_rdata, exp_v);
    end

    // Reset one cycle after a granted read on C (RD_LAT=2).
    tick();
    cpu_drv(1'b0, 9'h010, 32'h0);
    dbg_drv(1'b0, 9'h020, 32'h0);
    smp();
    check("mf_c_mem_rd", 32'(c_mem_rd),    32'd1);
    check("mf_c_stall",  32'(c_cpu_stall), 32'd0);
    tick();
    reset = 1'b1;
    smp();
    check("mf_rst_c_stall",     32'(c_cpu_stall),   32'd0);
    check("mf_rst_c_dbg_gnt",   32'(c_dbg_gnt),     32'd0);
    check("mf_rst_c_mem_rd",    32'(c_mem_rd),      32'd0);
    check("mf_rst_c_rvalid",    32'(c_cpu_rvalid),  32'd0);
    check("mf_rst_c_stall_cnt", 32'(c_stall_count), 32'd0);
    check("mf_rst_a_stall_cnt", 32'(a_stall_count), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      reset = 1'b0;
      smp();
      if (k < 2) check("mf_c_dropped_rvalid", 32'(c_cpu_rvalid), 32'd0);
      if (k == 0) check("mf_c_stall_cnt_zero", 32'(c_stall_count), 32'd0);
      check("mf_c_dbg_gnt", 32'(c_dbg_gnt), (k % 2 == 1) ? 32'd1 : 32'd0);
      check("mf_a_dbg_gnt", 32'(a_dbg_gnt), (k == 4) ? 32'd1 : 32'd0);
    end
    tick();
    idle();
    smp();
    check("mf_c_stall_cnt_end", 32'(c_stall_count), 32'd2);
    check("mf_a_stall_cnt_end", 32'(a_stall_count), 32'd1);
    for (int k = 0; k < 3; k++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
